oam_dma_arbiter: RTL and testbench
==================================

// Module: oam_dma_arbiter
// PURPOSE
// - Owns the external memory bus between the sm83 core and an OAM DMA engine; one bus master per cycle.
// - A CPU write to the DMA register copies DMA_LEN bytes from page {src,8'h00} to OAM at OAM_BASE.
// - While a copy runs, the CPU loses the bus except for HRAM (FF80-FFFE), which has its own port.
// - Sits between sm83 addr/d_out/write/d_in and the memory map decoder.
// PARAMETERS
// - DMA_LEN      160       bytes per transfer, 1..256
// - START_DELAY  1         idle cycles between the register write and the first DMA read, 0..7
// - DMA_REG      16'hFF46  DMA source register address
// - OAM_BASE     16'hFE00  destination base address
// PORTS
// - clk        in   1   clock; all state on posedge
// - rst        in   1   asynchronous, active-low reset
// - cpu_addr   in   16  sm83 address
// - cpu_wdata  in   8   sm83 write data
// - cpu_write  in   1   sm83 write strobe
// - cpu_rdata  out  8   read data returned to sm83
// - mem_addr   out  16  shared bus address
// - mem_wdata  out  8   shared bus write data
// - mem_write  out  1   shared bus write strobe
// - mem_rdata  in   8   shared bus read data
// - hram_addr  out  7   HRAM index, cpu_addr[6:0]
// - hram_we    out  1   HRAM write strobe
// - hram_wdata out  8   HRAM write data, = cpu_wdata
// - hram_rdata in   8   HRAM read data
// - dma_active out  1   high in READ/WRITE states
// BEHAVIOUR
// - State: 2-bit FSM {IDLE, DELAY, READ, WRITE}, 8-bit src reg, 8-bit idx, 3-bit delay counter, 8-bit byte buffer.
// - Reset (rst low, async):
//   - FSM=IDLE; src=8'h00; idx=0; delay counter and buffer cleared.
//   - Outputs while rst low: mem_addr=0, mem_write=0, hram_we=0, dma_active=0.
//   - Reset mid-transfer aborts the copy with no further OAM writes.
// - HRAM window (cpu_addr FF80-FFFE): always routed to the hram port, in every state.
//   - hram_we=cpu_write; cpu_rdata=hram_rdata; never forwarded to the mem bus.
// - DMA register (cpu_addr==DMA_REG): never forwarded to the mem bus.
//   - Read returns src.
//   - Write in IDLE or DELAY: src<=cpu_wdata, idx<=0, FSM<=DELAY loaded with START_DELAY (START_DELAY=0 goes straight to READ).
// - IDLE/DELAY, any other address: pass-through.
//   - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_write=cpu_write, cpu_rdata=mem_rdata.
// - DELAY: counter decrements each cycle; FSM->READ when it reaches 0.
// - READ (1 cycle):
//   - mem_addr={srcp,idx}, where srcp=src-8'h20 if src>=8'hE0 (echo map), else src.
//   - mem_write=0; buffer<=mem_rdata at clock edge; FSM->WRITE.
// - WRITE (1 cycle):
//   - mem_addr=OAM_BASE+idx, mem_wdata=buffer, mem_write=1.
//   - If idx==DMA_LEN-1: FSM->IDLE; else idx<=idx+1, FSM->READ.
// - Transfer length: exactly 2*DMA_LEN bus cycles after DELAY; dma_active falls the cycle after the last WRITE.
// - CPU during READ/WRITE, non-HRAM/non-DMA_REG: reads return 8'hFF; writes dropped; CPU cannot touch the mem bus.
// - DMA_REG write during READ/WRITE: see CONFIGURATION.
//   - A write in the final WRITE cycle counts as during-transfer.
// CONFIGURATION
// - OAM_DMA_RESTART_EN defined:
//   - A DMA_REG write during READ/WRITE loads src, sets idx=0 and enters DELAY, aborting the current copy.
//   - A WRITE on that same cycle still completes.
// - OAM_DMA_RESTART_EN undefined:
//   - A DMA_REG write during READ/WRITE is ignored; src unchanged; the transfer runs to completion.
// TESTING
// - Reset: hold rst low 3 cycles -> mem_write=0, dma_active=0, DMA_REG reads 8'h00.
// - Basic copy: write 8'hC1 to FF46, memory C100+i = i.
//   - dma_active rises after 1 DELAY cycle; 320 cycles follow.
//   - FE00..FE9F = 00..9F; exactly 160 mem_write pulses.
// - CPU blocking: read 8'h55 location at C000 mid-copy -> cpu_rdata=8'hFF.
//   - Write to C000 mid-copy -> memory unchanged.
//   - HRAM FF90 write/read of 8'hA5 mid-copy -> succeeds via the hram port.
// - Echo map: src=8'hFE -> reads addresses DE00..DE9F.
// - Restart: write 8'hC2 at byte 50 of a C1 copy.
//   - Macro defined: OAM finally holds C2 page data from FE00.
//   - Macro undefined: C1 copy completes; DMA_REG still reads 8'hC1.
// - Async reset asserted at byte 80 -> no further mem_write; FSM IDLE; FE50+ untouched.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// OAM DMA bus arbiter: shares the external memory bus between the sm83 core and an OAM copy engine.
// Optional feature: define OAM_DMA_RESTART_EN so a DMA register write during a copy restarts it.
module oam_dma_arbiter #(
  parameter int unsigned  DMA_LEN     = 160,
  parameter int unsigned  START_DELAY = 1,
  parameter logic [15:0]  DMA_REG     = 16'hFF46,
  parameter logic [15:0]  OAM_BASE    = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  hram_addr,
  output logic        hram_we,
  output logic [7:0]  hram_wdata,
  input  logic [7:0]  hram_rdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_e;

  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
  localparam logic [2:0] DELAY_LD  = 3'(START_DELAY);
`ifdef OAM_DMA_RESTART_EN
  localparam bit         RESTART   = 1'b1;
`else
  localparam bit         RESTART   = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] buf_q, buf_d;

  logic       is_hram;
  logic       is_dma_reg;
  logic       busy;
  logic [7:0] src_page;

  assign is_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
  assign is_dma_reg = (cpu_addr == DMA_REG);
  assign busy       = (state_q == READ) || (state_q == WRITE);
  // Sources in E0-FF read through the echo of C0-DF.
  assign src_page   = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  assign hram_addr  = cpu_addr[6:0];
  assign hram_wdata = cpu_wdata;
  assign dma_active = busy && rst;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_write = 1'b0;
    hram_we   = 1'b0;
    cpu_rdata = 8'hFF;

    if (is_hram) begin
      hram_we   = cpu_write;
      cpu_rdata = hram_rdata;
    end else if (is_dma_reg) begin
      cpu_rdata = src_q;
    end else if (!busy) begin
      mem_write = cpu_write;
      cpu_rdata = mem_rdata;
    end

    case (state_q)
      DELAY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = READ;
      end
      READ: begin
        mem_addr = {src_page, idx_q};
        buf_d    = mem_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        mem_addr  = OAM_BASE + {8'h00, idx_q};
        mem_wdata = buf_q;
        mem_write = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: ;
    endcase

    // A register write overrides the sequencing above; the bus outputs of this cycle stand.
    if (is_dma_reg && cpu_write && (!busy || RESTART)) begin
      src_d = cpu_wdata;
      idx_d = 8'h00;
      if (DELAY_LD == 3'd0) begin
        state_d = READ;
      end else begin
        state_d = DELAY;
        cnt_d   = DELAY_LD;
      end
    end

    if (!rst) begin
      mem_addr  = 16'h0000;
      mem_write = 1'b0;
      hram_we   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= 8'h00;
      idx_q   <= 8'h00;
      cnt_q   <= 3'd0;
      buf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a behavioural 64 KiB memory and 128-byte HRAM.
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [6:0]  hram_addr;
  logic        hram_we;
  logic [7:0]  hram_wdata;
  logic [7:0]  hram_rdata;
  logic        dma_active;

  logic [7:0]  mem  [0:65535];
  logic [7:0]  hram [0:127];
  int          wr_cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .hram_addr(hram_addr), .hram_we(hram_we), .hram_wdata(hram_wdata), .hram_rdata(hram_rdata),
    .dma_active(dma_active)
  );

  assign mem_rdata  = mem[mem_addr];
  assign hram_rdata = hram[hram_addr];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (hram_we) hram[hram_addr] <= hram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_dma(input logic [7:0] s);
    @(negedge clk);
    cpu_addr = 16'hFF46; cpu_wdata = s; cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 2000), 32'd1);
  endtask

  task automatic fill_oam();
    for (int i = 0; i < 256; i++) mem[16'hFE00 + 16'(i)] = 8'hEE;
  endtask

  function automatic int oam_bad(input int first, input int last, input int kind);
    int bad = 0;
    logic [7:0] e;
    for (int i = first; i <= last; i++) begin
      case (kind)
        0: e = 8'(i);
        1: e = 8'(i) + 8'h30;
        2: e = ~8'(i);
        default: e = 8'hEE;
      endcase
      if (mem[16'hFE00 + 16'(i)] !== e) bad++;
    end
    return bad;
  endfunction

  initial begin
    int active;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 128; i++) hram[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'hC100 + 16'(i)] = 8'(i);
      mem[16'hC200 + 16'(i)] = 8'(i) + 8'h30;
      mem[16'hDE00 + 16'(i)] = ~8'(i);
    end
    mem[16'hC000] = 8'h55;
    fill_oam();
    wr_cnt = 0;
    cpu_addr = 16'hFF46; cpu_wdata = 8'h00; cpu_write = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_dma_reg", 32'(cpu_rdata), 32'h00);
    rst = 1'b1;

    // Pass-through in IDLE
    @(negedge clk);
    cpu_addr = 16'hD000; cpu_wdata = 8'h3C; cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0;
    #1 check("idle_write", 32'(mem[16'hD000]), 32'h3C);
    check("idle_read", 32'(cpu_rdata), 32'h3C);

    // Basic copy
    wr_cnt = 0;
    start_dma(8'hC1);
    check("delay_inactive", 32'(dma_active), 32'd0);
    @(negedge clk);
    check("active_rise", 32'(dma_active), 32'd1);
    check("first_read_addr", 32'(mem_addr), 32'hC100);
    active = 1;
    while (dma_active && active < 2000) begin
      @(negedge clk);
      if (dma_active) active++;
    end
    check("active_cycles", 32'(active), 32'd320);
    check("basic_writes", 32'(wr_cnt), 32'd160);
    check("basic_oam", 32'(oam_bad(0, 159, 0)), 32'd0);
    check("basic_oam_tail", 32'(oam_bad(160, 255, 3)), 32'd0);

    // CPU blocked during copy; HRAM still reachable
    wr_cnt = 0;
    start_dma(8'hC1);
    repeat (11) @(negedge clk);
    cpu_addr = 16'hC000;
    #1 check("blocked_read", 32'(cpu_rdata), 32'hFF);
    cpu_wdata = 8'h77; cpu_write = 1'b1;
    repeat (2) @(negedge clk);
    cpu_write = 1'b0;
    cpu_addr = 16'hFF90; cpu_wdata = 8'hA5; cpu_write = 1'b1;
    #1 check("hram_we", 32'(hram_we), 32'd1);
    @(negedge clk);
    cpu_write = 1'b0;
    #1 check("hram_read", 32'(cpu_rdata), 32'hA5);
    check("hram_mid_copy", 32'(dma_active), 32'd1);
    cpu_addr = 16'h0000;
    wait_idle("blocked_timeout");
    check("blocked_write", 32'(mem[16'hC000]), 32'h55);
    check("blocked_count", 32'(wr_cnt), 32'd160);

    // Echo map
    fill_oam();
    start_dma(8'hFE);
    @(negedge clk);
    check("echo_first_addr", 32'(mem_addr), 32'hDE00);
    wait_idle("echo_timeout");
    check("echo_oam", 32'(oam_bad(0, 159, 2)), 32'd0);
    cpu_addr = 16'hFF46;
    #1 check("echo_reg", 32'(cpu_rdata), 32'hFE);

    // Restart request at byte 50
    fill_oam();
    wr_cnt = 0;
    start_dma(8'hC1);
    @(negedge clk);
    repeat (100) @(negedge clk);
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC2; cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0; cpu_addr = 16'h0000;
    repeat (400) @(negedge clk);
    check("restart_idle", 32'(dma_active), 32'd0);
    cpu_addr = 16'hFF46;
`ifdef OAM_DMA_RESTART_EN
    #1 check("restart_reg", 32'(cpu_rdata), 32'hC2);
    check("restart_oam", 32'(oam_bad(0, 159, 1)), 32'd0);
`else
    #1 check("restart_reg", 32'(cpu_rdata), 32'hC1);
    check("restart_oam", 32'(oam_bad(0, 159, 0)), 32'd0);
    check("restart_count", 32'(wr_cnt), 32'd160);
`endif

    // Async reset at byte 80
    fill_oam();
    wr_cnt = 0;
    start_dma(8'hC1);
    @(negedge clk);
    repeat (160) @(negedge clk);
    rst = 1'b0;
    #1 check("arst_mem_write", 32'(mem_write), 32'd0);
    check("arst_dma_active", 32'(dma_active), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_idle", 32'(dma_active), 32'd0);
    check("arst_count", 32'(wr_cnt), 32'd80);
    check("arst_head", 32'(oam_bad(0, 79, 0)), 32'd0);
    check("arst_tail", 32'(oam_bad(80, 159, 3)), 32'd0);
    cpu_addr = 16'hFF46;
    #1 check("arst_reg", 32'(cpu_rdata), 32'h00);
    cpu_addr = 16'hC000;
    #1 check("arst_passthru", 32'(cpu_rdata), 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
